// File: rtl/uart_boot_loader.sv
// uart_boot_loader
// Collects a little-endian word-count header and payload words from uart_rx,
// writes the words to consecutive instruction-memory addresses, holds the core
// in reset while loading, and answers the host with one ACK or NAK byte.
module uart_boot_loader #(
  parameter int          ADDR_WIDTH = 14,
  parameter int          BASE_ADDR  = 0,
  parameter logic [7:0]  ACK_BYTE   = 8'hAA,
  parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            rdata,
  input  logic                  rdata_ready,
  input  logic                  ferr,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  cpu_rstn,
  output logic                  load_done,
  output logic [1:0]            err_code
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_ACK  = 3'd2,
    S_DONE = 3'd3,
    S_NAK  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Largest word count that still fits above BASE_ADDR; 33 bits so that a
  // full 32-bit header can be compared without wrap.
  localparam logic [32:0] LIMIT = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_bidx, w_bidx_nxt;
  logic [23:0]           r_asm, w_asm_nxt;
  logic [31:0]           r_n, w_n_nxt;
  logic [31:0]           r_wcnt, w_wcnt_nxt;
  logic                  r_imem_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_imem_addr, w_addr_nxt;
  logic [31:0]           r_imem_wdata, w_wdata_nxt;
  logic                  r_tx_start, w_tx_start_nxt;
  logic [7:0]            r_tx_data, w_tx_data_nxt;
  logic                  r_done;
  logic [1:0]            r_err_code, w_err_nxt;

  logic                  w_collecting;
  logic                  w_accept;
  logic [31:0]           w_word;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  // The fourth byte completes a word straight from rdata, so the assembly
  // register only has to hold the three lower bytes.
  assign w_collecting = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_accept     = w_collecting && rdata_ready && !ferr;
  assign w_word       = {rdata, r_asm};
  assign w_wr_addr    = ADDR_WIDTH'(32'(BASE_ADDR) + r_wcnt);

  // State register and all registered outputs; everything returns to its
  // idle value immediately on reset so a partial load is abandoned.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_HDR;
      r_bidx       <= 2'd0;
      r_asm        <= 24'd0;
      r_n          <= 32'd0;
      r_wcnt       <= 32'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= ADDR_WIDTH'(BASE_ADDR);
      r_imem_wdata <= 32'd0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= 8'd0;
      r_done       <= 1'b0;
      r_err_code   <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_bidx       <= w_bidx_nxt;
      r_asm        <= w_asm_nxt;
      r_n          <= w_n_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_imem_we    <= w_we_nxt;
      r_imem_addr  <= w_addr_nxt;
      r_imem_wdata <= w_wdata_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_done       <= (w_state_nxt == S_DONE);
      r_err_code   <= w_err_nxt;
    end
  end

  // Next-state logic: byte assembly, header check, memory writes, reply.
  always_comb begin
    w_state_nxt    = r_state;
    w_bidx_nxt     = r_bidx;
    w_asm_nxt      = r_asm;
    w_n_nxt        = r_n;
    w_wcnt_nxt     = r_wcnt;
    w_we_nxt       = 1'b0;
    w_addr_nxt     = r_imem_addr;
    w_wdata_nxt    = r_imem_wdata;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_err_nxt      = r_err_code;

    if (w_accept) begin
      w_bidx_nxt = r_bidx + 2'd1;
      case (r_bidx)
        2'd0:    w_asm_nxt[7:0]   = rdata;
        2'd1:    w_asm_nxt[15:8]  = rdata;
        2'd2:    w_asm_nxt[23:16] = rdata;
        default: w_asm_nxt        = r_asm;
      endcase
    end

    case (r_state)
      S_HDR: begin
        if (ferr) begin
          if (r_err_code == 2'd0) w_err_nxt = 2'd1;
          w_state_nxt   = S_NAK;
          w_tx_data_nxt = NAK_BYTE;
        end else if (w_accept && (r_bidx == 2'd3)) begin
          w_n_nxt = w_word;
          if ({1'b0, w_word} > LIMIT) begin
            if (r_err_code == 2'd0) w_err_nxt = 2'd2;
            w_state_nxt   = S_NAK;
            w_tx_data_nxt = NAK_BYTE;
          end else if (w_word == 32'd0) begin
            w_state_nxt   = S_ACK;
            w_tx_data_nxt = ACK_BYTE;
          end else begin
            w_state_nxt = S_DATA;
            w_wcnt_nxt  = 32'd0;
          end
        end
      end
      S_DATA: begin
        if (ferr) begin
          if (r_err_code == 2'd0) w_err_nxt = 2'd1;
          w_state_nxt   = S_NAK;
          w_tx_data_nxt = NAK_BYTE;
        end else if (w_accept && (r_bidx == 2'd3)) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = w_wr_addr;
          w_wdata_nxt = w_word;
          w_wcnt_nxt  = r_wcnt + 32'd1;
          if ((r_wcnt + 32'd1) == r_n) begin
            w_state_nxt   = S_ACK;
            w_tx_data_nxt = ACK_BYTE;
          end
        end
      end
      S_ACK: begin
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = S_DONE;
        end
      end
      S_NAK: begin
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = S_ERR;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign cpu_rstn   = r_done;
  assign load_done  = r_done;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: normal loads, empty load, size
// overflow, framing error, transmitter back-pressure and async reset.
module tb_uart_boot_loader;

  localparam int AW = 14;

  logic          clk;
  logic          rstn;
  logic [7:0]    rdata;
  logic          rdata_ready;
  logic          ferr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          cpu_rstn;
  logic          load_done;
  logic [1:0]    err_code;

  int n_checks = 0;
  int n_errors = 0;

  // Observed write and transmit traffic, cleared while reset is low.
  int          wr_cnt = 0;
  int          tx_cnt = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  logic [7:0]  tx_last = 8'd0;

  uart_boot_loader #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (0),
    .ACK_BYTE   (8'hAA),
    .NAK_BYTE   (8'h15)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .ferr        (ferr),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .cpu_rstn    (cpu_rstn),
    .load_done   (load_done),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse and transmit request on the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      wr_cnt = 0;
      tx_cnt = 0;
      tx_last = 8'd0;
    end else begin
      if (imem_we) begin
        if (wr_cnt < 8) begin
          wr_addr[wr_cnt] = 32'(imem_addr);
          wr_data[wr_cnt] = imem_wdata;
        end
        wr_cnt = wr_cnt + 1;
      end
      if (tx_start) begin
        tx_cnt = tx_cnt + 1;
        tx_last = tx_data;
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rdata = b;
    rdata_ready = 1'b1;
    @(negedge clk);
    rdata_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    rdata = 8'd0;
    rdata_ready = 1'b0;
    ferr = 1'b0;
    tx_busy = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(1);

    // Reset values.
    chk_eq("rst_we",    32'(imem_we),    32'd0);
    chk_eq("rst_addr",  32'(imem_addr),  32'd0);
    chk_eq("rst_wdata", imem_wdata,      32'd0);
    chk_eq("rst_txs",   32'(tx_start),   32'd0);
    chk_eq("rst_txd",   32'(tx_data),    32'd0);
    chk_eq("rst_cpu",   32'(cpu_rstn),   32'd0);
    chk_eq("rst_done",  32'(load_done),  32'd0);
    chk_eq("rst_err",   32'(err_code),   32'd0);

    // Single word.
    send_word(32'd1);
    send_word(32'hDEADBEEF);
    chk_eq("w1_we_pulse", 32'(imem_we),  32'd1);
    chk_eq("w1_cpu_early", 32'(cpu_rstn), 32'd0);
    chk_eq("w1_tx_early", 32'(tx_start), 32'd0);
    idle(5);
    chk_eq("w1_wr_cnt", 32'(wr_cnt),   32'd1);
    chk_eq("w1_addr",   wr_addr[0],    32'd0);
    chk_eq("w1_data",   wr_data[0],    32'hDEADBEEF);
    chk_eq("w1_tx_cnt", 32'(tx_cnt),   32'd1);
    chk_eq("w1_tx_byte", 32'(tx_last), 32'hAA);
    chk_eq("w1_cpu",    32'(cpu_rstn), 32'd1);
    chk_eq("w1_done",   32'(load_done), 32'd1);
    chk_eq("w1_err",    32'(err_code), 32'd0);

    // Three words.
    do_reset();
    send_word(32'd3);
    send_word(32'h03020100);
    send_word(32'h13121110);
    chk_eq("w3_tx_mid", 32'(tx_cnt), 32'd0);
    send_word(32'h23222120);
    idle(5);
    chk_eq("w3_wr_cnt", 32'(wr_cnt),   32'd3);
    chk_eq("w3_addr0",  wr_addr[0],    32'd0);
    chk_eq("w3_addr1",  wr_addr[1],    32'd1);
    chk_eq("w3_addr2",  wr_addr[2],    32'd2);
    chk_eq("w3_data0",  wr_data[0],    32'h03020100);
    chk_eq("w3_data1",  wr_data[1],    32'h13121110);
    chk_eq("w3_data2",  wr_data[2],    32'h23222120);
    chk_eq("w3_tx_cnt", 32'(tx_cnt),   32'd1);
    chk_eq("w3_tx_byte", 32'(tx_last), 32'hAA);
    chk_eq("w3_done",   32'(load_done), 32'd1);

    // Empty load.
    do_reset();
    send_word(32'd0);
    idle(5);
    chk_eq("e_wr_cnt",  32'(wr_cnt),   32'd0);
    chk_eq("e_tx_cnt",  32'(tx_cnt),   32'd1);
    chk_eq("e_tx_byte", 32'(tx_last),  32'hAA);
    chk_eq("e_done",    32'(load_done), 32'd1);
    chk_eq("e_cpu",     32'(cpu_rstn), 32'd1);

    // Largest legal count is accepted: loader waits for payload.
    do_reset();
    send_word(32'h00004000);
    idle(5);
    chk_eq("max_tx_cnt", 32'(tx_cnt),  32'd0);
    chk_eq("max_err",   32'(err_code), 32'd0);

    // Size overflow, followed by ignored bytes.
    do_reset();
    send_word(32'h00004001);
    send_word(32'h55667788);
    idle(5);
    chk_eq("ov_wr_cnt", 32'(wr_cnt),   32'd0);
    chk_eq("ov_err",    32'(err_code), 32'd2);
    chk_eq("ov_tx_cnt", 32'(tx_cnt),   32'd1);
    chk_eq("ov_tx_byte", 32'(tx_last), 32'h15);
    chk_eq("ov_cpu",    32'(cpu_rstn), 32'd0);
    chk_eq("ov_done",   32'(load_done), 32'd0);

    // Framing error after two payload bytes, coincident with a byte.
    do_reset();
    send_word(32'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    ferr = 1'b1;
    rdata = 8'hCC;
    rdata_ready = 1'b1;
    @(negedge clk);
    ferr = 1'b0;
    rdata_ready = 1'b0;
    send_byte(8'hDD);
    idle(5);
    chk_eq("fe_wr_cnt", 32'(wr_cnt),   32'd0);
    chk_eq("fe_err",    32'(err_code), 32'd1);
    chk_eq("fe_tx_cnt", 32'(tx_cnt),   32'd1);
    chk_eq("fe_tx_byte", 32'(tx_last), 32'h15);
    chk_eq("fe_cpu",    32'(cpu_rstn), 32'd0);

    // Transmitter busy at ACK time.
    do_reset();
    tx_busy = 1'b1;
    send_word(32'd1);
    send_word(32'h11223344);
    idle(100);
    chk_eq("bz_tx_held", 32'(tx_cnt),  32'd0);
    chk_eq("bz_done_held", 32'(load_done), 32'd0);
    chk_eq("bz_wr_cnt", 32'(wr_cnt),   32'd1);
    tx_busy = 1'b0;
    idle(5);
    chk_eq("bz_tx_cnt", 32'(tx_cnt),   32'd1);
    chk_eq("bz_tx_byte", 32'(tx_last), 32'hAA);
    chk_eq("bz_done",   32'(load_done), 32'd1);

    // New load aborted by an asynchronous reset mid-word.
    do_reset();
    send_word(32'd2);
    send_word(32'h44332211);
    send_byte(8'h99);
    send_byte(8'h88);
    idle(2);
    chk_eq("ar_wr_cnt", 32'(wr_cnt),   32'd1);
    chk_eq("ar_pre_wdata", imem_wdata, 32'h44332211);
    #3;
    rstn = 1'b0;
    #1;
    chk_eq("ar_we",    32'(imem_we),   32'd0);
    chk_eq("ar_addr",  32'(imem_addr), 32'd0);
    chk_eq("ar_wdata", imem_wdata,     32'd0);
    chk_eq("ar_txs",   32'(tx_start),  32'd0);
    chk_eq("ar_txd",   32'(tx_data),   32'd0);
    chk_eq("ar_cpu",   32'(cpu_rstn),  32'd0);
    chk_eq("ar_done",  32'(load_done), 32'd0);
    chk_eq("ar_err",   32'(err_code),  32'd0);
    idle(2);
    rstn = 1'b1;
    idle(3);
    chk_eq("ar_post_wr", 32'(wr_cnt),  32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
